// File: rtl/mcu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mcu_mem_arbiter_if
//   Bundle of the cache, DMA and memory-controller signals around the
//   memory-port arbiter.
//   slave  : arbiter view (requests/acks in, grants/mem drive out)
//   master : environment view (cache, DMA and memory controller)
//   Signals:
//     cache_req/we/addr/wdata  cache request side
//     dma_mcu_access           grant to cache
//     dma_req/we/addr/wdata    DMA request side
//     dma_grant                grant to DMA
//     mem_do_act/we/addr/dataintomem  memory-controller command
//     mem_ack                  memory-controller acknowledge
//     cache_ack/dma_ack        ack routed to the current owner
//     arb_timeout              watchdog release pulse
// ---------------------------------------------------------------------------
interface mcu_mem_arbiter_if;
    logic        cache_req;
    logic        cache_we;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic        dma_mcu_access;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_grant;
    logic        mem_do_act;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataintomem;
    logic        mem_ack;
    logic        cache_ack;
    logic        dma_ack;
    logic        arb_timeout;

    modport slave (
        input  cache_req, cache_we, cache_addr, cache_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_ack,
        output dma_mcu_access, dma_grant,
        output mem_do_act, mem_we, mem_addr, mem_dataintomem,
        output cache_ack, dma_ack, arb_timeout
    );

    modport master (
        output cache_req, cache_we, cache_addr, cache_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_ack,
        input  dma_mcu_access, dma_grant,
        input  mem_do_act, mem_we, mem_addr, mem_dataintomem,
        input  cache_ack, dma_ack, arb_timeout
    );
endinterface

// File: rtl/mcu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mcu_mem_arbiter
//   Shares the single memory-controller port between the cache and the DMA
//   engine. Cache has fixed priority; a DMA request that has waited
//   STARVE_LIMIT cycles wins the next arbitration. Every ownership ends with
//   exactly one TURN cycle in which nobody drives the port.
//
//   Ports:
//     MCU_CLK  clock
//     RST      asynchronous active-low reset
//     bus      mcu_mem_arbiter_if.slave (cache, DMA and memory signals)
//
//   Parameters:
//     STARVE_LIMIT  DMA wait cycles before it overrides cache priority (>=1)
//     WDOG_CYCLES   owner cycles without mem_ack before forced release (>=2)
//
//   Build option:
//     ARB_WATCHDOG_EN  enables the ownership watchdog and arb_timeout pulse;
//                      without it arb_timeout is tied 0 and an owner may hold
//                      the port indefinitely.
// ---------------------------------------------------------------------------
module mcu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned WDOG_CYCLES  = 256
) (
    input  logic              MCU_CLK,
    input  logic              RST,
    mcu_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CACHE = 2'd1,
        S_DMA   = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_starve_cnt;
    logic            w_starve;
    logic            w_owner;
    logic            w_wdog_hit;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    assign w_starve = (r_starve_cnt == CW'(STARVE_LIMIT));
    assign w_owner  = (r_state == S_CACHE) || (r_state == S_DMA);

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES);

    logic [WW-1:0] r_wdog_cnt;
    logic          r_timeout;

    // Counter holds (elapsed owner cycles - 1) so the hit lands in the
    // WDOG_CYCLES-th ackless owner cycle and TURN follows on that edge.
    assign w_wdog_hit = w_owner && !bus.mem_ack &&
                        (r_wdog_cnt == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge MCU_CLK or negedge RST) begin
        if (!RST) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_wdog_hit;
            if (!w_owner || bus.mem_ack || w_wdog_hit)
                r_wdog_cnt <= '0;
            else
                r_wdog_cnt <= r_wdog_cnt + WW'(1);
        end
    end

    assign bus.arb_timeout = r_timeout;
`else
    assign w_wdog_hit      = 1'b0;
    assign bus.arb_timeout = 1'b0;
`endif

    // Next-state logic. The released owner always passes through TURN, so
    // a still-high request after a forced release is re-arbitrated in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.dma_req && (w_starve || !bus.cache_req))
                    w_next = S_DMA;
                else if (bus.cache_req)
                    w_next = S_CACHE;
            end
            S_CACHE: if (!bus.cache_req || w_wdog_hit) w_next = S_TURN;
            S_DMA:   if (!bus.dma_req   || w_wdog_hit) w_next = S_TURN;
            S_TURN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge MCU_CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Starvation counter: cleared when DMA is granted, saturates at the limit.
    always_ff @(posedge MCU_CLK or negedge RST) begin
        if (!RST)
            r_starve_cnt <= '0;
        else if (w_next == S_DMA && r_state != S_DMA)
            r_starve_cnt <= '0;
        else if (bus.dma_req && r_state != S_DMA && !w_starve)
            r_starve_cnt <= r_starve_cnt + CW'(1);
    end

    // Address/data hold registers so the memory bus stays quiet between
    // owners instead of toggling with whatever the requesters drive.
    always_ff @(posedge MCU_CLK or negedge RST) begin
        if (!RST) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_CACHE) begin
            r_addr  <= bus.cache_addr;
            r_wdata <= bus.cache_wdata;
        end else if (r_state == S_DMA) begin
            r_addr  <= bus.dma_addr;
            r_wdata <= bus.dma_wdata;
        end
    end

    assign bus.dma_mcu_access = (r_state == S_CACHE);
    assign bus.dma_grant      = (r_state == S_DMA);

    always_comb begin
        bus.mem_do_act      = 1'b0;
        bus.mem_we          = 1'b0;
        bus.mem_addr        = r_addr;
        bus.mem_dataintomem = r_wdata;
        case (r_state)
            S_CACHE: begin
                bus.mem_do_act      = bus.cache_req;
                bus.mem_we          = bus.cache_we;
                bus.mem_addr        = bus.cache_addr;
                bus.mem_dataintomem = bus.cache_wdata;
            end
            S_DMA: begin
                bus.mem_do_act      = bus.dma_req;
                bus.mem_we          = bus.dma_we;
                bus.mem_addr        = bus.dma_addr;
                bus.mem_dataintomem = bus.dma_wdata;
            end
            default: ;
        endcase
    end

    // Acks follow the registered grant, so IDLE/TURN acks go nowhere.
    assign bus.cache_ack = bus.mem_ack && (r_state == S_CACHE);
    assign bus.dma_ack   = bus.mem_ack && (r_state == S_DMA);

endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mcu_mem_arbiter
//   Directed bench for mcu_mem_arbiter (STARVE_LIMIT=8, WDOG_CYCLES=16).
//   Inputs change 1 ns after the rising edge; outputs are sampled
//   mid-cycle.
// ---------------------------------------------------------------------------
module tb_mcu_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mcu_mem_arbiter_if bus ();

    mcu_mem_arbiter #(
        .STARVE_LIMIT (8),
        .WDOG_CYCLES  (16)
    ) dut (
        .MCU_CLK (clk),
        .RST     (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.cache_req   = 1'b1;
        bus.cache_we    = 1'b0;
        bus.cache_addr  = 32'h0000_0000;
        bus.cache_wdata = 32'h0000_0000;
        bus.dma_req     = 1'b1;
        bus.dma_we      = 1'b0;
        bus.dma_addr    = 32'h0000_0000;
        bus.dma_wdata   = 32'h0000_0000;
        bus.mem_ack     = 1'b1;

        // Reset held with both requests high.
        step(2);
        chk("rst_cache_grant", 32'(bus.dma_mcu_access), 32'd0);
        chk("rst_dma_grant",   32'(bus.dma_grant),      32'd0);
        chk("rst_do_act",      32'(bus.mem_do_act),     32'd0);
        chk("rst_mem_we",      32'(bus.mem_we),         32'd0);
        chk("rst_mem_addr",    bus.mem_addr,            32'd0);
        chk("rst_mem_data",    bus.mem_dataintomem,     32'd0);
        chk("rst_acks",        {30'd0, bus.cache_ack, bus.dma_ack}, 32'd0);
        chk("rst_timeout",     32'(bus.arb_timeout),    32'd0);

        // Release after edge N; grant appears after edge N+1.
        bus.mem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_no_grant_yet", 32'(bus.dma_mcu_access), 32'd0);
        step(1);
        chk("sim_cache_wins",  32'(bus.dma_mcu_access), 32'd1);
        chk("sim_dma_waits",   32'(bus.dma_grant),      32'd0);
        chk("sim_do_act",      32'(bus.mem_do_act),     32'd1);

        // Cache withdraws: one TURN, IDLE, then DMA.
        bus.cache_req = 1'b0;
        #1;
        chk("withdraw_do_act", 32'(bus.mem_do_act), 32'd0);
        step(1);
        chk("turn_grants",  {30'd0, bus.dma_mcu_access, bus.dma_grant}, 32'd0);
        chk("turn_do_act",  32'(bus.mem_do_act), 32'd0);
        step(1);
        chk("idle_grants",  {30'd0, bus.dma_mcu_access, bus.dma_grant}, 32'd0);
        step(1);
        chk("dma_granted",  32'(bus.dma_grant),  32'd1);
        chk("dma_do_act",   32'(bus.mem_do_act), 32'd1);
        chk("dma_starve0",  32'(dut.r_starve_cnt), 32'd0);

        // Ack routing while DMA owns the port.
        bus.mem_ack = 1'b1;
        #1;
        chk("ack_to_dma",    32'(bus.dma_ack),   32'd1);
        chk("ack_not_cache", 32'(bus.cache_ack), 32'd0);
        bus.mem_ack = 1'b0;
        bus.dma_req = 1'b0;
        step(1);
        bus.mem_ack = 1'b1;
        #1;
        chk("turn_ack_drop", {30'd0, bus.cache_ack, bus.dma_ack}, 32'd0);
        step(1);
        chk("turn_ack_idle", {30'd0, bus.dma_mcu_access, bus.dma_grant}, 32'd0);
        bus.mem_ack = 1'b0;

        // Cache write path, then starvation while cache holds 10 cycles.
        bus.cache_req = 1'b1;
        step(1);
        bus.cache_we    = 1'b1;
        bus.cache_addr  = 32'h0000_1234;
        bus.cache_wdata = 32'hDEAD_BEEF;
        bus.dma_req     = 1'b1;
        bus.dma_addr    = 32'hA5A5_0040;
        bus.dma_wdata   = 32'h0BAD_F00D;
        #1;
        chk("wr_grant",   32'(bus.dma_mcu_access), 32'd1);
        chk("wr_mem_we",  32'(bus.mem_we),          32'd1);
        chk("wr_addr",    bus.mem_addr,             32'h0000_1234);
        chk("wr_data",    bus.mem_dataintomem,      32'hDEAD_BEEF);
        step(10);
        chk("starve_hold_cache", 32'(bus.dma_mcu_access), 32'd1);
        chk("starve_saturated",  32'(dut.r_starve_cnt),    32'd8);
        bus.cache_req = 1'b0;
        bus.cache_we  = 1'b0;
        step(1);
        chk("hold_addr_turn", bus.mem_addr,        32'h0000_1234);
        chk("hold_data_turn", bus.mem_dataintomem, 32'hDEAD_BEEF);
        chk("hold_we_turn",   32'(bus.mem_we),     32'd0);
        bus.cache_req = 1'b1;
        step(1);
        chk("starve_idle", {30'd0, bus.dma_mcu_access, bus.dma_grant}, 32'd0);
        step(1);
        chk("starve_dma_wins",  32'(bus.dma_grant),      32'd1);
        chk("starve_cache_out", 32'(bus.dma_mcu_access), 32'd0);
        chk("starve_cnt_clr",   32'(dut.r_starve_cnt),   32'd0);
        chk("dma_addr_mux",     bus.mem_addr,            32'hA5A5_0040);

        // Async reset in the middle of a cache transaction.
        bus.dma_req = 1'b0;
        step(3);
        chk("cache_again", 32'(bus.dma_mcu_access), 32'd1);
        bus.mem_ack = 1'b1;
        #1;
        chk("cache_ack", 32'(bus.cache_ack), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_grant",  32'(bus.dma_mcu_access), 32'd0);
        chk("arst_do_act", 32'(bus.mem_do_act),     32'd0);
        chk("arst_ack",    32'(bus.cache_ack),      32'd0);
        bus.mem_ack   = 1'b0;
        bus.cache_req = 1'b0;
        bus.dma_req   = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("wd_dma_own", 32'(bus.dma_grant), 32'd1);

`ifdef ARB_WATCHDOG_EN
        // DMA holds without any ack: released after 16 owner cycles.
        step(15);
        chk("wd_still_own", 32'(bus.dma_grant),   32'd1);
        chk("wd_no_pulse",  32'(bus.arb_timeout), 32'd0);
        step(1);
        chk("wd_turn",      32'(bus.dma_grant),   32'd0);
        chk("wd_pulse",     32'(bus.arb_timeout), 32'd1);
        step(1);
        chk("wd_pulse_end", 32'(bus.arb_timeout), 32'd0);
        step(1);
        chk("wd_regrant",   32'(bus.dma_grant),   32'd1);
`else
        // No watchdog: owner keeps the port well past 16 cycles.
        step(20);
        chk("nowd_hold",    32'(bus.dma_grant),   32'd1);
        chk("nowd_timeout", 32'(bus.arb_timeout), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
